iter_shifter: RTL and testbench



---
 rtl/iter_shifter.sv | 115 +++++++++++
 tb/tb_iter_shifter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/iter_shifter.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROTR by a variable amount, at most STEP
// bit positions per clock, under a start/busy/done handshake.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; busy=0, done=0
// S_SHIFT | shifting min(rem, STEP) positions per clock; busy=1
// S_DONE  | result valid, one-cycle done pulse; start re-accepts at once
module iter_shifter #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5,
   parameter int STEP    = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [1:0]         mode,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [WIDTH-1:0]   data_in,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   data_out
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [1:0] M_SLL  = 2'b00;
   localparam logic [1:0] M_SRL  = 2'b01;
   localparam logic [1:0] M_SRA  = 2'b10;
   localparam logic [1:0] M_ROTR = 2'b11;

   // One extra bit so STEP == WIDTH is representable.
   localparam logic [SHAMT_W:0] STEP_C  = (SHAMT_W+1)'(STEP);
   localparam logic [SHAMT_W:0] WIDTH_C = (SHAMT_W+1)'(WIDTH);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   work_q, work_d;
   logic [SHAMT_W-1:0] rem_q, rem_d;
   logic [1:0]         mode_q, mode_d;
   logic               sign_q, sign_d;

   logic [SHAMT_W:0]   step_k;
   logic [WIDTH-1:0]   fill_mask;
   logic [WIDTH-1:0]   work_shifted;

   always_comb begin
      step_k       = ({1'b0, rem_q} < STEP_C) ? {1'b0, rem_q} : STEP_C;
      fill_mask    = ~({WIDTH{1'b1}} >> step_k);
      work_shifted = work_q;
      case (mode_q)
         M_SLL:   work_shifted = work_q << step_k;
         M_SRL:   work_shifted = work_q >> step_k;
         // Fill comes from the latched operand sign, not the moving MSB.
         M_SRA:   work_shifted = (work_q >> step_k) | (sign_q ? fill_mask : '0);
         M_ROTR:  work_shifted = (work_q >> step_k) | (work_q << (WIDTH_C - step_k));
         default: work_shifted = work_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      rem_d   = rem_q;
      mode_d  = mode_q;
      sign_d  = sign_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            done = (state_q == S_DONE);
            if (start) begin
               state_d = S_SHIFT;
               work_d  = data_in;
               rem_d   = shamt;
               mode_d  = mode;
               sign_d  = data_in[WIDTH-1];
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SHIFT: begin
            busy   = 1'b1;
            work_d = work_shifted;
            rem_d  = rem_q - step_k[SHAMT_W-1:0];
            if (rem_d == '0) begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         work_q  <= '0;
         rem_q   <= '0;
         mode_q  <= M_SLL;
         sign_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         rem_q   <= rem_d;
         mode_q  <= mode_d;
         sign_q  <= sign_d;
      end
   end

   assign data_out = work_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed and swept checks of iter_shifter with STEP=4 (default), STEP=1
// and STEP=32 instances sharing one stimulus bus.
module tb_iter_shifter;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  mode;
   logic [4:0]  shamt;
   logic [31:0] data_in;

   logic        busy4, done4, busy1, done1, busy32, done32;
   logic [31:0] dout4, dout1, dout32;

   int n_cmp = 0;
   int n_bad = 0;

   int lat4, lat1, lat32, busy_cnt4;

   always #5 clk = ~clk;

   iter_shifter u_s4 (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .shamt(shamt),
      .data_in(data_in), .busy(busy4), .done(done4), .data_out(dout4)
   );

   iter_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u_s1 (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .shamt(shamt),
      .data_in(data_in), .busy(busy1), .done(done1), .data_out(dout1)
   );

   iter_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(32)) u_s32 (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .shamt(shamt),
      .data_in(data_in), .busy(busy32), .done(done32), .data_out(dout32)
   );

   function automatic logic [31:0] ref_shift(input logic [1:0] m, input logic [4:0] s,
                                             input logic [31:0] d);
      logic [31:0] r;
      int          si;
      si = int'(s);
      case (m)
         2'b00:   r = d << si;
         2'b01:   r = d >> si;
         2'b10:   r = 32'($signed(d) >>> si);
         default: r = (si == 0) ? d : ((d >> si) | (d << (32 - si)));
      endcase
      return r;
   endfunction

   // Accept one op on all instances and record the edge (accept = 1) after
   // which each instance shows done; -1 means it never did within budget.
   task automatic run_op(input logic [1:0] m, input logic [4:0] s, input logic [31:0] d);
      @(negedge clk);
      start = 1'b1; mode = m; shamt = s; data_in = d;
      lat4 = -1; lat1 = -1; lat32 = -1; busy_cnt4 = 0;
      for (int e = 1; e <= 40; e++) begin
         @(negedge clk);
         if (e == 1) start = 1'b0;
         if (busy4) busy_cnt4++;
         if (done4 && lat4 < 0) lat4 = e;
         if (done1 && lat1 < 0) lat1 = e;
         if (done32 && lat32 < 0) lat32 = e;
         if (lat4 >= 0 && lat1 >= 0 && lat32 >= 0) break;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; mode = 2'b00; shamt = '0; data_in = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy4); end
      n_cmp++; if (done4 !== 1'b0) begin n_bad++; $display("FAIL reset_done got %0b want 0", done4); end
      n_cmp++; if (dout4 !== 32'h0) begin n_bad++; $display("FAIL reset_dout got %h want 0", dout4); end
      n_cmp++; if ({busy1, done1, busy32, done32} !== 4'b0) begin
         n_bad++; $display("FAIL reset_other got %b want 0000", {busy1, done1, busy32, done32});
      end
   endtask

   task automatic test_sll_legacy;
      @(negedge clk);
      start = 1'b1; mode = 2'b00; shamt = 5'd2; data_in = 32'h0000_1234;
      @(negedge clk);
      start = 1'b0;
      n_cmp++; if ({busy4, done4} !== 2'b10) begin n_bad++; $display("FAIL sll_shift_cycle got %b want 10", {busy4, done4}); end
      @(negedge clk);
      n_cmp++; if ({busy4, done4} !== 2'b01) begin n_bad++; $display("FAIL sll_done_cycle got %b want 01", {busy4, done4}); end
      n_cmp++; if (dout4 !== 32'h0000_48D0) begin n_bad++; $display("FAIL sll_result got %h want 000048d0", dout4); end
      @(negedge clk);
      n_cmp++; if ({busy4, done4} !== 2'b00) begin n_bad++; $display("FAIL sll_done_pulse got %b want 00", {busy4, done4}); end
      n_cmp++; if (dout4 !== 32'h0000_48D0) begin n_bad++; $display("FAIL sll_hold got %h want 000048d0", dout4); end
   endtask

   task automatic test_sra_srl;
      run_op(2'b10, 5'd31, 32'h8000_0000);
      n_cmp++; if (busy_cnt4 !== 8) begin n_bad++; $display("FAIL sra_busy_cycles got %0d want 8", busy_cnt4); end
      n_cmp++; if (lat4 !== 9) begin n_bad++; $display("FAIL sra_latency got %0d want 9", lat4); end
      n_cmp++; if (dout4 !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sra_result got %h want ffffffff", dout4); end
      run_op(2'b01, 5'd31, 32'h8000_0000);
      n_cmp++; if (dout4 !== 32'h0000_0001) begin n_bad++; $display("FAIL srl_result got %h want 00000001", dout4); end
   endtask

   task automatic test_rotr;
      run_op(2'b11, 5'd4, 32'h0000_00F1);
      n_cmp++; if (dout4 !== 32'h1000_000F) begin n_bad++; $display("FAIL rotr4_result got %h want 1000000f", dout4); end
      n_cmp++; if (lat4 !== 2) begin n_bad++; $display("FAIL rotr4_latency got %0d want 2", lat4); end
      run_op(2'b11, 5'd0, 32'h0000_00F1);
      n_cmp++; if (dout4 !== 32'h0000_00F1) begin n_bad++; $display("FAIL rotr0_result got %h want 000000f1", dout4); end
      n_cmp++; if (busy_cnt4 !== 1) begin n_bad++; $display("FAIL rotr0_busy_cycles got %0d want 1", busy_cnt4); end
   endtask

   task automatic test_back_to_back;
      int e;
      e = -1;
      @(negedge clk);
      start = 1'b1; mode = 2'b00; shamt = 5'd20; data_in = 32'hABCD_EF01;
      @(negedge clk);          // after accept edge: SHIFT cycle 1
      start = 1'b0;
      repeat (2) @(negedge clk); // SHIFT cycle 3
      start = 1'b1; mode = 2'b01; shamt = 5'd1; data_in = 32'h1234_5678;
      @(negedge clk);
      start = 1'b0;
      for (int i = 5; i <= 15; i++) begin
         if (done4) begin e = i - 1; break; end
         @(negedge clk);
      end
      n_cmp++; if (e !== 6) begin n_bad++; $display("FAIL ignore_latency got %0d want 6", e); end
      n_cmp++; if (dout4 !== 32'hF010_0000) begin n_bad++; $display("FAIL ignore_result got %h want f0100000", dout4); end
      // Re-accept in the DONE cycle.
      start = 1'b1; mode = 2'b01; shamt = 5'd4; data_in = 32'hF000_0000;
      @(negedge clk);
      start = 1'b0;
      n_cmp++; if ({busy4, done4} !== 2'b10) begin n_bad++; $display("FAIL b2b_no_idle got %b want 10", {busy4, done4}); end
      @(negedge clk);
      n_cmp++; if (done4 !== 1'b1) begin n_bad++; $display("FAIL b2b_done got %b want 1", done4); end
      n_cmp++; if (dout4 !== 32'h0F00_0000) begin n_bad++; $display("FAIL b2b_result got %h want 0f000000", dout4); end
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      start = 1'b1; mode = 2'b00; shamt = 5'd20; data_in = 32'hFFFF_FFFF;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      n_cmp++; if ({busy4, done4} !== 2'b00) begin n_bad++; $display("FAIL rstmid_flags got %b want 00", {busy4, done4}); end
      n_cmp++; if (dout4 !== 32'h0) begin n_bad++; $display("FAIL rstmid_dout got %h want 0", dout4); end
      @(negedge clk);
      n_cmp++; if ({busy4, done4} !== 2'b00) begin n_bad++; $display("FAIL rstmid_idle got %b want 00", {busy4, done4}); end
      run_op(2'b01, 5'd3, 32'h0000_0080);
      n_cmp++; if (dout4 !== 32'h0000_0010) begin n_bad++; $display("FAIL rstmid_after got %h want 00000010", dout4); end
      n_cmp++; if (lat4 !== 2) begin n_bad++; $display("FAIL rstmid_after_lat got %0d want 2", lat4); end
   endtask

   task automatic test_sweep;
      logic [31:0] d, exp_r;
      int          n4;
      for (int m = 0; m < 4; m++) begin
         for (int s = 0; s < 32; s++) begin
            d     = $urandom;
            if (s == 31) d[31] = 1'b1;
            exp_r = ref_shift(2'(m), 5'(s), d);
            n4    = (s == 0) ? 1 : (s + 3) / 4;
            run_op(2'(m), 5'(s), d);
            n_cmp++; if (dout4 !== exp_r) begin n_bad++; $display("FAIL sweep_s4 m=%0d s=%0d d=%h got %h want %h", m, s, d, dout4, exp_r); end
            n_cmp++; if (dout1 !== exp_r) begin n_bad++; $display("FAIL sweep_s1 m=%0d s=%0d d=%h got %h want %h", m, s, d, dout1, exp_r); end
            n_cmp++; if (dout32 !== exp_r) begin n_bad++; $display("FAIL sweep_s32 m=%0d s=%0d d=%h got %h want %h", m, s, d, dout32, exp_r); end
            n_cmp++; if (lat4 !== 1 + n4) begin n_bad++; $display("FAIL sweep_lat4 m=%0d s=%0d got %0d want %0d", m, s, lat4, 1 + n4); end
            n_cmp++; if (lat1 !== 1 + ((s == 0) ? 1 : s)) begin n_bad++; $display("FAIL sweep_lat1 m=%0d s=%0d got %0d want %0d", m, s, lat1, 1 + ((s == 0) ? 1 : s)); end
            n_cmp++; if (lat32 !== 2) begin n_bad++; $display("FAIL sweep_lat32 m=%0d s=%0d got %0d want 2", m, s, lat32); end
         end
      end
   endtask

   initial begin
      test_reset;
      test_sll_legacy;
      test_sra_srl;
      test_rotr;
      test_back_to_back;
      test_reset_mid;
      test_sweep;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
